// File: rtl/frame_scan_pkg.sv
// Shared state encoding, default geometry and RAM address packing for the frame scan reader.
package frame_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_DISPLAY
    } scan_state_e;

    localparam int DEF_COLUMNS   = 64;
    localparam int DEF_ROW_PAIRS = 16;
    localparam int DEF_ON_CYCLES = 64;
    localparam int DEF_COL_W     = $clog2(DEF_COLUMNS);
    localparam int DEF_ROW_W     = $clog2(DEF_ROW_PAIRS);
    localparam int DEF_ADDR_W    = 1 + DEF_ROW_W + DEF_COL_W;

    // Builds {frame_buf, row, col}; the caller truncates to its own address width.
    function automatic logic [31:0] pack_addr(input logic frame_buf, input logic [15:0] row,
                                              input logic [15:0] col, input int row_w,
                                              input int col_w);
        return (32'(frame_buf) << (row_w + col_w)) | (32'(row) << col_w) | 32'(col);
    endfunction

endpackage

// File: rtl/frame_scan_column_timer.sv
// Slot/phase sequencer for one row shift: COLUMNS+1 slots of two phases each.
module frame_scan_column_timer
    import frame_scan_pkg::*;
#(
    parameter int COLUMNS = DEF_COLUMNS
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         advance_i,
    output logic                         phase_o,
    output logic [$clog2(COLUMNS+1)-1:0] slot_o,
    output logic                         last_o
);

    localparam int SLOT_W = $clog2(COLUMNS + 1);

    logic              phase_q, phase_d;
    logic [SLOT_W-1:0] slot_q, slot_d;

    // phase_o/slot_o describe the cycle after the coming edge, so the owner can register outputs.
    always_comb begin
        phase_d = phase_q;
        slot_d  = slot_q;
        if (clear_i) begin
            phase_d = 1'b0;
            slot_d  = '0;
        end else if (advance_i) begin
            phase_d = ~phase_q;
            slot_d  = slot_q + SLOT_W'(phase_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= 1'b0;
            slot_q  <= '0;
        end else begin
            phase_q <= phase_d;
            slot_q  <= slot_d;
        end
    end

    assign phase_o = phase_d;
    assign slot_o  = slot_d;
    assign last_o  = (int'(slot_q) == COLUMNS) && phase_q;

endmodule

// File: rtl/frame_scan_reader.sv
// Double-buffered HUB75-style scan reader feeding a monochrome panel from frame RAM port B.
// Define FRAME_SCAN_BRIGHTNESS_EN to add Brightness_i, which shortens the OE window per frame.
module frame_scan_reader
    import frame_scan_pkg::*;
#(
    parameter int COLUMNS    = DEF_COLUMNS,
    parameter int ROW_PAIRS  = DEF_ROW_PAIRS,
    parameter int ADDR_WIDTH = DEF_ADDR_W,
    parameter int ON_CYCLES  = DEF_ON_CYCLES
) (
    input  logic                         Clock_i,
    input  logic                         Reset_i,
    input  logic                         Enable_i,
    input  logic                         FrameSelect_i,
    output logic [ADDR_WIDTH-1:0]        ReadAddress_o,
    output logic                         ReadClockEn_o,
    input  logic [1:0]                   ReadData_i,
`ifdef FRAME_SCAN_BRIGHTNESS_EN
    input  logic [7:0]                   Brightness_i,
`endif
    output logic                         PanelClk_o,
    output logic                         PanelLatch_o,
    output logic                         PanelOE_n_o,
    output logic [$clog2(ROW_PAIRS)-1:0] PanelRow_o,
    output logic [1:0]                   PanelData_o,
    output logic                         FrameDone_o,
    output logic                         Busy_o
);

    localparam int COL_W  = $clog2(COLUMNS);
    localparam int ROW_W  = $clog2(ROW_PAIRS);
    localparam int SLOT_W = $clog2(COLUMNS + 1);
    localparam int DISP_W = $clog2(ON_CYCLES + 1);

    scan_state_e       state_q, state_d;
    logic              fbuf_q, fbuf_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [DISP_W-1:0] disp_q, disp_d;

    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  rce_q, rce_d;
    logic                  pclk_q, pclk_d;
    logic                  plat_q, plat_d;
    logic                  oen_q, oen_d;
    logic [ROW_W-1:0]      prow_q, prow_d;
    logic [1:0]            pdata_q, pdata_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic              phase_nxt;
    logic [SLOT_W-1:0] slot_nxt;
    logic              slot_last;

`ifdef FRAME_SCAN_BRIGHTNESS_EN
    logic [7:0] bright_q, bright_d;
`endif

    frame_scan_column_timer #(
        .COLUMNS (COLUMNS)
    ) u_column_timer (
        .clk_i     (Clock_i),
        .rst_i     (Reset_i),
        .clear_i   (state_q != ST_SHIFT),
        .advance_i ((state_q == ST_SHIFT) && !slot_last),
        .phase_o   (phase_nxt),
        .slot_o    (slot_nxt),
        .last_o    (slot_last)
    );

    always_comb begin
        state_d = state_q;
        fbuf_d  = fbuf_q;
        row_d   = row_q;
        disp_d  = disp_q;
        raddr_d = raddr_q;
        pdata_d = pdata_q;
        prow_d  = prow_q;
        rce_d   = 1'b0;
        pclk_d  = 1'b0;
        plat_d  = 1'b0;
        oen_d   = 1'b1;
        done_d  = 1'b0;
`ifdef FRAME_SCAN_BRIGHTNESS_EN
        bright_d = bright_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (Enable_i) begin
                    state_d = ST_SHIFT;
                    fbuf_d  = FrameSelect_i;
                    row_d   = '0;
`ifdef FRAME_SCAN_BRIGHTNESS_EN
                    bright_d = Brightness_i;
`endif
                end
            end
            ST_SHIFT: begin
                if (slot_last) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                state_d = ST_DISPLAY;
                disp_d  = '0;
            end
            ST_DISPLAY: begin
                disp_d = disp_q + DISP_W'(1);
                if (int'(disp_q) == ON_CYCLES - 1) begin
                    if (int'(row_q) == ROW_PAIRS - 1) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                        row_d   = row_q + ROW_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are derived from the state entered on this edge.
        // Slot k phase0 issues column k and captures column k-1, whose read returned one cycle earlier.
        unique case (state_d)
            ST_SHIFT: begin
                rce_d = 1'b1;
                if (!phase_nxt && int'(slot_nxt) < COLUMNS)
                    raddr_d = ADDR_WIDTH'(pack_addr(fbuf_d, 16'(row_d), 16'(slot_nxt), ROW_W, COL_W));
                if (!phase_nxt && slot_nxt != '0)
                    pdata_d = ReadData_i;
                pclk_d = phase_nxt && (slot_nxt != '0);
            end
            ST_LATCH: begin
                plat_d = 1'b1;
                prow_d = row_q;
            end
            ST_DISPLAY: begin
`ifdef FRAME_SCAN_BRIGHTNESS_EN
                oen_d = !(int'(disp_d) < int'(bright_q));
`else
                oen_d = 1'b0;
`endif
            end
            default: ;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state_q <= ST_IDLE;
            fbuf_q  <= 1'b0;
            row_q   <= '0;
            disp_q  <= '0;
            raddr_q <= '0;
            rce_q   <= 1'b0;
            pclk_q  <= 1'b0;
            plat_q  <= 1'b0;
            oen_q   <= 1'b1;
            prow_q  <= '0;
            pdata_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fbuf_q  <= fbuf_d;
            row_q   <= row_d;
            disp_q  <= disp_d;
            raddr_q <= raddr_d;
            rce_q   <= rce_d;
            pclk_q  <= pclk_d;
            plat_q  <= plat_d;
            oen_q   <= oen_d;
            prow_q  <= prow_d;
            pdata_q <= pdata_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

`ifdef FRAME_SCAN_BRIGHTNESS_EN
    always_ff @(posedge Clock_i) begin
        if (Reset_i) bright_q <= '0;
        else         bright_q <= bright_d;
    end
`endif

    assign ReadAddress_o = raddr_q;
    assign ReadClockEn_o = rce_q;
    assign PanelClk_o    = pclk_q;
    assign PanelLatch_o  = plat_q;
    assign PanelOE_n_o   = oen_q;
    assign PanelRow_o    = prow_q;
    assign PanelData_o   = pdata_q;
    assign FrameDone_o   = done_q;
    assign Busy_o        = busy_q;

endmodule

// File: doc/frame_scan_reader.md
Name: frame_scan_reader

Overview:
Read-side consumer of the 2x2048 dual-port frame RAM. It scans the RAM read port with a 1-cycle registered read latency and drives a HUB75-style monochrome panel: shift clock, latch, active-low output enable, row address, and 2 data bits (top half, bottom half). It is double-buffered: address bit 10 selects the frame, sampled at each frame start. It sits between the frame RAM read port and the panel pins; the writer owns RAM port A.

Parameters:
COLUMNS, 64, pixels per panel row; power of 2.
ROW_PAIRS, 16, scanned row pairs; power of 2.
ADDR_WIDTH, 11, RAM address width; must equal 1 + clog2(ROW_PAIRS) + clog2(COLUMNS).
ON_CYCLES, 64, DISPLAY-state length in clocks; ≥1.

Ports:
Clock  in  1  single system clock; all logic on rising edge.
Reset  in  1  synchronous, active-high reset.
Enable  in  1  permits starting a new frame; sampled only in IDLE.
FrameSelect  in  1  buffer to display; latched on IDLE→SHIFT.
ReadAddress  out  ADDR_WIDTH  RAM port B address = {buf, row, col}.
ReadClockEn  out  1  RAM port B clock enable.
ReadData  in  2  RAM port B data {bottom, top}; valid 1 cycle after address.
PanelClk  out  1  panel shift clock.
PanelLatch  out  1  panel latch strobe.
PanelOE_n  out  1  panel output enable, active low.
PanelRow  out  clog2(ROW_PAIRS)  panel row address.
PanelData  out  2  {bottom, top} pixel bits.
FrameDone  out  1  one-cycle pulse at end of frame.
Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous): state=IDLE; ReadAddress=0, ReadClockEn=0, PanelClk=0, PanelLatch=0, PanelOE_n=1, PanelRow=0, PanelData=0, FrameDone=0, Busy=0. Reset mid-frame aborts immediately. No partial latch, and OE_n is forced high on the next edge.
- States: IDLE, SHIFT, LATCH, DISPLAY. All outputs are registered.
- IDLE: if Enable=1, then buf<=FrameSelect, row<=0, and go to SHIFT. Otherwise stay.
- SHIFT: COLUMNS+1 slots of 2 cycles each (phase0, phase1), so 2*(COLUMNS+1) cycles total. ReadClockEn=1 and PanelOE_n=1 throughout.
  - Slot k phase0 (k<COLUMNS): ReadAddress={buf,row,k}.
  - Slot k phase0 (k≥1): PanelData<=ReadData (column k-1), PanelClk=0.
  - Slot k phase1 (k≥1): PanelClk=1.
  - Slot 0 emits no clock pulse. This gives exactly COLUMNS PanelClk rising edges, each with PanelData stable for 1 prior cycle.
  - After slot COLUMNS phase1: PanelClk returns to 0 and the block goes to LATCH.
- LATCH: 1 cycle. PanelLatch=1, PanelRow<=row on the same edge, ReadClockEn=0.
- DISPLAY: ON_CYCLES cycles with PanelOE_n=0 (subject to the optional feature). Exit edge: PanelOE_n<=1.
  - If row==ROW_PAIRS-1: FrameDone=1 for 1 cycle, go to IDLE.
  - Otherwise: row<=row+1, go to SHIFT.
- Counters wrap only by explicit reset to 0 at state entry; the column counter never exceeds COLUMNS.
- Changes to FrameSelect mid-frame are ignored. Enable falling mid-frame does not stop the frame; it is checked only in IDLE.
- Row period = 2*(COLUMNS+1)+1+ON_CYCLES clocks (195 at defaults). Frame = ROW_PAIRS*195 + 1 IDLE clock = 3121 at defaults with Enable held high.

Optional Feature:
FRAME_SCAN_BRIGHTNESS_EN
- Defined: adds input Brightness[7:0], latched with FrameSelect at frame start. In DISPLAY, PanelOE_n=0 only for the first min(Brightness, ON_CYCLES) cycles, then 1. DISPLAY length is unchanged, so timing is identical. Brightness=0 means the panel stays dark.
- Undefined: the port is absent and PanelOE_n=0 for all ON_CYCLES.

Decomposition:
- Package frame_scan_pkg:
  - state enum (IDLE/SHIFT/LATCH/DISPLAY);
  - default COLUMNS/ROW_PAIRS/ON_CYCLES constants;
  - address-field width localparams and an address-pack function.
- One natural sub-module, frame_scan_column_timer: slot/phase counter producing phase, slot index, last-slot flag.

Test Plan:
- Reset, then Enable=1 and FrameSelect=1 → first ReadAddress=0x400. Exactly 64 PanelClk rises before the first PanelLatch, and PanelLatch is seen with PanelRow=0.
- RAM model with data(addr)=addr[1:0] → PanelData at the n-th PanelClk rise equals (n-1)[1:0] for rows 0..15.
- Read-latency check: model returns data 1 cycle after ReadAddress with ReadClockEn=1 → no column shift or duplication; column 63 is captured in slot 64.
- Full frame with Enable held high → FrameDone pulses once at cycle 3120 after IDLE exit. PanelOE_n is low for exactly 16×64 cycles per frame and is never low while PanelClk toggles or PanelLatch=1.
- Reset asserted in SHIFT row 5 column 20 → next cycle PanelOE_n=1, PanelClk=0, Busy=0. Restart begins at row 0.
- FRAME_SCAN_BRIGHTNESS_EN with Brightness=16 → PanelOE_n low for 16 of 64 DISPLAY cycles per row. With Brightness=0 it is never low; with Brightness=255 it is low for all 64.
